// File: rtl/float_divider.sv
// rtl/float_divider.sv - IEEE-754 single-precision divider z = a / b
// Restoring quotient (one bit per cycle), round-to-nearest-even, denormal in/out, stb/ack handshake.

module float_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic        input_b_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   localparam logic [3:0] ST_GET_A   = 4'd0;
   localparam logic [3:0] ST_GET_B   = 4'd1;
   localparam logic [3:0] ST_UNPACK  = 4'd2;
   localparam logic [3:0] ST_SPECIAL = 4'd3;
   localparam logic [3:0] ST_NORM_A  = 4'd4;
   localparam logic [3:0] ST_NORM_B  = 4'd5;
   localparam logic [3:0] ST_DIV_0   = 4'd6;
   localparam logic [3:0] ST_DIV_1   = 4'd7;
   localparam logic [3:0] ST_DIV_2   = 4'd8;
   localparam logic [3:0] ST_NORM_1  = 4'd9;
   localparam logic [3:0] ST_NORM_2  = 4'd10;
   localparam logic [3:0] ST_ROUND   = 4'd11;
   localparam logic [3:0] ST_PACK    = 4'd12;
   localparam logic [3:0] ST_PUT_Z   = 4'd13;

   localparam logic signed [9:0] EXP_BIAS    = 10'sd127;
   localparam logic signed [9:0] EXP_SPECIAL = 10'sd128;
   localparam logic signed [9:0] EXP_ZERO    = -10'sd127;
   localparam logic signed [9:0] EXP_MIN     = -10'sd126;
   localparam logic [31:0]       QNAN        = 32'hFFC0_0000;

   logic [3:0]        state;
   logic [31:0]       a, b, z;
   logic [23:0]       a_m, b_m, z_m;
   logic signed [9:0] a_e, b_e, z_e;
   logic              a_s, b_s, z_s;
   logic              guard, round_bit, sticky;
   logic [24:0]       rem;
   logic [26:0]       quo;
   logic [4:0]        bit_cnt;

   logic              div_ge;
   logic [24:0]       rem_sub;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   always_comb begin
      div_ge  = rem >= {1'b0, b_m};
      rem_sub = div_ge ? rem - {1'b0, b_m} : rem;
   end

   // Classification relies on the unpacked form: field 255 -> 128, field 0 -> -127.
   assign a_nan  = (a_e == EXP_SPECIAL) && (a_m != 24'd0);
   assign b_nan  = (b_e == EXP_SPECIAL) && (b_m != 24'd0);
   assign a_inf  = (a_e == EXP_SPECIAL) && (a_m == 24'd0);
   assign b_inf  = (b_e == EXP_SPECIAL) && (b_m == 24'd0);
   assign a_zero = (a_e == EXP_ZERO) && (a_m == 24'd0);
   assign b_zero = (b_e == EXP_ZERO) && (b_m == 24'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_GET_A;
         input_a_ack  <= 1'b0;
         input_b_ack  <= 1'b0;
         output_z     <= 32'd0;
         output_z_stb <= 1'b0;
      end else begin
         case (state)
            ST_GET_A: begin
               input_a_ack <= 1'b1;
               if (input_a_ack && input_a_stb) begin
                  a           <= input_a;
                  input_a_ack <= 1'b0;
                  state       <= ST_GET_B;
               end
            end

            ST_GET_B: begin
               input_b_ack <= 1'b1;
               if (input_b_ack && input_b_stb) begin
                  b           <= input_b;
                  input_b_ack <= 1'b0;
                  state       <= ST_UNPACK;
               end
            end

            ST_UNPACK: begin
               a_m   <= {1'b0, a[22:0]};
               b_m   <= {1'b0, b[22:0]};
               a_e   <= $signed({2'b00, a[30:23]}) - EXP_BIAS;
               b_e   <= $signed({2'b00, b[30:23]}) - EXP_BIAS;
               a_s   <= a[31];
               b_s   <= b[31];
               state <= ST_SPECIAL;
            end

            ST_SPECIAL: begin
               state <= ST_PUT_Z;
               if (a_nan || b_nan) begin
                  z <= QNAN;
               end else if (a_inf && b_inf) begin
                  z <= QNAN;
               end else if (a_inf) begin
                  z <= {a_s ^ b_s, 8'hFF, 23'd0};
               end else if (b_inf) begin
                  z <= {a_s ^ b_s, 31'd0};
               end else if (b_zero) begin
                  z <= a_zero ? QNAN : {a_s ^ b_s, 8'hFF, 23'd0};
               end else if (a_zero) begin
                  z <= {a_s ^ b_s, 31'd0};
               end else begin
                  if (a_e == EXP_ZERO) a_e <= EXP_MIN;
                  else                 a_m[23] <= 1'b1;
                  if (b_e == EXP_ZERO) b_e <= EXP_MIN;
                  else                 b_m[23] <= 1'b1;
                  state <= ST_NORM_A;
               end
            end

            ST_NORM_A: begin
               if (!a_m[23]) begin
                  a_m <= a_m << 1;
                  a_e <= a_e - 10'sd1;
               end else begin
                  state <= ST_NORM_B;
               end
            end

            ST_NORM_B: begin
               if (!b_m[23]) begin
                  b_m <= b_m << 1;
                  b_e <= b_e - 10'sd1;
               end else begin
                  state <= ST_DIV_0;
               end
            end

            ST_DIV_0: begin
               z_s     <= a_s ^ b_s;
               z_e     <= a_e - b_e;
               rem     <= {1'b0, a_m};
               quo     <= 27'd0;
               bit_cnt <= 5'd26;
               state   <= ST_DIV_1;
            end

            // Quotient bits enter at the LSB, so after 27 steps the first one sits at bit 26.
            ST_DIV_1: begin
               quo <= {quo[25:0], div_ge};
               rem <= rem_sub << 1;
               if (bit_cnt == 5'd0) state <= ST_DIV_2;
               else                 bit_cnt <= bit_cnt - 5'd1;
            end

            ST_DIV_2: begin
               z_m       <= quo[26:3];
               guard     <= quo[2];
               round_bit <= quo[1];
               sticky    <= quo[0] | (rem != 25'd0);
               state     <= ST_NORM_1;
            end

            ST_NORM_1: begin
               if (!z_m[23]) begin
                  z_m       <= {z_m[22:0], guard};
                  guard     <= round_bit;
                  round_bit <= 1'b0;
                  z_e       <= z_e - 10'sd1;
               end else begin
                  state <= ST_NORM_2;
               end
            end

            // Denormalise until the exponent reaches the smallest normal value.
            ST_NORM_2: begin
               if (z_e < EXP_MIN) begin
                  z_e       <= z_e + 10'sd1;
                  z_m       <= z_m >> 1;
                  guard     <= z_m[0];
                  round_bit <= guard;
                  sticky    <= sticky | round_bit;
               end else begin
                  state <= ST_ROUND;
               end
            end

            ST_ROUND: begin
               if (guard && (round_bit || sticky || z_m[0])) begin
                  z_m <= z_m + 24'd1;
                  if (z_m == 24'hFF_FFFF) z_e <= z_e + 10'sd1;
               end
               state <= ST_PACK;
            end

            ST_PACK: begin
               z[31]    <= z_s;
               z[30:23] <= z_e[7:0] + 8'd127;
               z[22:0]  <= z_m[22:0];
               if (z_e == EXP_MIN && !z_m[23]) z[30:23] <= 8'd0;
               if (z_e > 10'sd127) z <= {z_s, 8'hFF, 23'd0};
               state <= ST_PUT_Z;
            end

            ST_PUT_Z: begin
               output_z_stb <= 1'b1;
               output_z     <= z;
               if (output_z_stb && output_z_ack) begin
                  output_z_stb <= 1'b0;
                  state        <= ST_GET_A;
               end
            end

            default: state <= ST_GET_A;
         endcase
      end
   end

endmodule

// File: tb/tb_float_divider.sv
// tb/tb_float_divider.sv - directed and randomised-stall checks of float_divider
// Expected quotients are hand-computed; the random pass uses an integer-division reference.

module tb_float_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] input_a = 32'd0;
   logic        input_a_stb = 1'b0;
   logic        input_a_ack;
   logic [31:0] input_b = 32'd0;
   logic        input_b_stb = 1'b0;
   logic        input_b_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack = 1'b0;

   int assertions = 0;
   int failures   = 0;
   int cyc        = 0;

   float_divider dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .input_b      (input_b),
      .input_b_stb  (input_b_stb),
      .input_b_ack  (input_b_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time exceeded, cycle=%0d", cyc);
      $fatal(1);
   end

   // Integer long-division reference for normal operands with a normal result.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] num, den, q, r;
      logic [24:0] mant;
      logic        g, st;
      int          e;
      num = {40'd0, 1'b1, a[22:0]} << 25;
      den = {40'd0, 1'b1, b[22:0]};
      q   = num / den;
      r   = num % den;
      e   = int'(a[30:23]) - int'(b[30:23]);
      if (q[25]) begin
         mant = {1'b0, q[25:2]};
         g    = q[1];
         st   = q[0] | (r != 64'd0);
      end else begin
         mant = {1'b0, q[24:1]};
         g    = q[0];
         st   = (r != 64'd0);
         e    = e - 1;
      end
      if (g && (st || mant[0])) mant = mant + 25'd1;
      if (mant[24]) begin
         mant = mant >> 1;
         e    = e + 1;
      end
      return {a[31] ^ b[31], 8'(e + 127), mant[22:0]};
   endfunction

   task automatic send_ops(input logic [31:0] va, input logic [31:0] vb, input int da, input int db,
                           input bit b_early, output int bcyc);
      int   t;
      logic b_ack_early;
      b_ack_early = 1'b0;
      input_a = va;
      input_b = vb;
      if (b_early) input_b_stb = 1'b1;
      for (int i = 0; i < da; i++) begin
         @(negedge clk);
         b_ack_early |= input_b_ack;
      end
      input_a_stb = 1'b1;
      t = 0;
      while (!input_a_ack && t < 200) begin
         @(negedge clk);
         b_ack_early |= input_b_ack;
         t++;
      end
      assertions++;
      if (input_a_ack !== 1'b1) begin
         failures++;
         $display("FAIL a_accept_timeout: input_a_ack=%b required 1", input_a_ack);
      end
      @(negedge clk);
      input_a_stb = 1'b0;
      assertions++;
      if (b_ack_early !== 1'b0) begin
         failures++;
         $display("FAIL b_ack_before_a: input_b_ack seen=%b required 0", b_ack_early);
      end
      if (!b_early) for (int i = 0; i < db; i++) @(negedge clk);
      input_b_stb = 1'b1;
      t = 0;
      while (!input_b_ack && t < 200) begin
         @(negedge clk);
         t++;
      end
      assertions++;
      if (input_b_ack !== 1'b1) begin
         failures++;
         $display("FAIL b_accept_timeout: input_b_ack=%b required 1", input_b_ack);
      end
      @(negedge clk);
      input_b_stb = 1'b0;
      bcyc = cyc;
   endtask

   task automatic get_z(input int bcyc, input bit do_ack, output logic [31:0] zv, output int lat);
      int t;
      t = 0;
      while (!output_z_stb && t < 400) begin
         @(negedge clk);
         t++;
      end
      assertions++;
      if (output_z_stb !== 1'b1) begin
         failures++;
         $display("FAIL z_timeout: output_z_stb=%b required 1", output_z_stb);
      end
      zv  = output_z;
      lat = cyc - bcyc;
      if (do_ack) begin
         output_z_ack = 1'b1;
         @(negedge clk);
         output_z_ack = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      assertions++;
      if (output_z !== 32'd0) begin failures++; $display("FAIL reset_z: got %h required 00000000", output_z); end
      assertions++;
      if (output_z_stb !== 1'b0) begin failures++; $display("FAIL reset_stb: got %b required 0", output_z_stb); end
      assertions++;
      if (input_a_ack !== 1'b0) begin failures++; $display("FAIL reset_a_ack: got %b required 0", input_a_ack); end
      assertions++;
      if (input_b_ack !== 1'b0) begin failures++; $display("FAIL reset_b_ack: got %b required 0", input_b_ack); end
      rst = 1'b0;
      @(negedge clk);
      assertions++;
      if (input_a_ack !== 1'b1) begin failures++; $display("FAIL post_reset_a_ack: got %b required 1", input_a_ack); end
      assertions++;
      if (input_b_ack !== 1'b0) begin failures++; $display("FAIL post_reset_b_ack: got %b required 0", input_b_ack); end
   endtask

   task automatic test_normal;
      logic [31:0] va[3]  = '{32'h40C0_0000, 32'h3F80_0000, 32'hC0C0_0000};
      logic [31:0] vb[3]  = '{32'h4000_0000, 32'h4040_0000, 32'h4000_0000};
      logic [31:0] exp[3] = '{32'h4040_0000, 32'h3EAA_AAAB, 32'hC040_0000};
      int          el[3]  = '{38, 39, 38};
      logic [31:0] zv;
      int          bcyc, lat;
      for (int i = 0; i < 3; i++) begin
         send_ops(va[i], vb[i], 0, 0, 1'b0, bcyc);
         get_z(bcyc, 1'b1, zv, lat);
         assertions++;
         if (zv !== exp[i]) begin
            failures++;
            $display("FAIL normal_value[%0d]: got %h required %h", i, zv, exp[i]);
         end
         assertions++;
         if (lat != el[i]) begin
            failures++;
            $display("FAIL normal_latency[%0d]: got %0d required %0d", i, lat, el[i]);
         end
      end
   endtask

   task automatic test_special;
      logic [31:0] va[10]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h3F80_0000,
                               32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 32'h8000_0000};
      logic [31:0] vb[10]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000,
                               32'h3F80_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
      logic [31:0] exp[10] = '{32'h7F80_0000, 32'hFF80_0000, 32'hFFC0_0000, 32'hFFC0_0000, 32'h0000_0000,
                               32'hFFC0_0000, 32'hFFC0_0000, 32'h7F80_0000, 32'h0000_0000, 32'h8000_0000};
      logic [31:0] zv;
      int          bcyc, lat;
      for (int i = 0; i < 10; i++) begin
         send_ops(va[i], vb[i], 0, 0, 1'b0, bcyc);
         get_z(bcyc, 1'b1, zv, lat);
         assertions++;
         if (zv !== exp[i]) begin
            failures++;
            $display("FAIL special_value[%0d]: got %h required %h", i, zv, exp[i]);
         end
         assertions++;
         if (lat != 3) begin
            failures++;
            $display("FAIL special_latency[%0d]: got %0d required 3", i, lat);
         end
      end
   endtask

   task automatic test_range;
      logic [31:0] va[3]  = '{32'h7F7F_FFFF, 32'h0080_0000, 32'h0000_0001};
      logic [31:0] vb[3]  = '{32'h3F00_0000, 32'h4000_0000, 32'h3F80_0000};
      logic [31:0] exp[3] = '{32'h7F80_0000, 32'h0040_0000, 32'h0000_0001};
      int          el[3]  = '{38, 39, 84};
      logic [31:0] zv;
      int          bcyc, lat;
      for (int i = 0; i < 3; i++) begin
         send_ops(va[i], vb[i], 0, 0, 1'b0, bcyc);
         get_z(bcyc, 1'b1, zv, lat);
         assertions++;
         if (zv !== exp[i]) begin
            failures++;
            $display("FAIL range_value[%0d]: got %h required %h", i, zv, exp[i]);
         end
         assertions++;
         if (lat != el[i]) begin
            failures++;
            $display("FAIL range_latency[%0d]: got %0d required %0d", i, lat, el[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] zv;
      int          bcyc, lat;
      logic        bad_stb, bad_z, bad_ack;
      bad_stb = 1'b0; bad_z = 1'b0; bad_ack = 1'b0;
      send_ops(32'h40C0_0000, 32'h4000_0000, 0, 0, 1'b0, bcyc);
      get_z(bcyc, 1'b0, zv, lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bad_stb |= (output_z_stb !== 1'b1);
         bad_z   |= (output_z !== 32'h4040_0000);
         bad_ack |= (input_a_ack !== 1'b0);
      end
      assertions++;
      if (bad_stb) begin failures++; $display("FAIL bp_stb_hold: stb dropped=%b required 0", bad_stb); end
      assertions++;
      if (bad_z) begin failures++; $display("FAIL bp_z_hold: z changed=%b required 0 (last %h)", bad_z, output_z); end
      assertions++;
      if (bad_ack) begin failures++; $display("FAIL bp_a_ack: a_ack seen=%b required 0", bad_ack); end
      output_z_ack = 1'b1;
      @(negedge clk);
      output_z_ack = 1'b0;
      assertions++;
      if (output_z_stb !== 1'b0) begin failures++; $display("FAIL bp_stb_clear: got %b required 0", output_z_stb); end
      assertions++;
      if (input_a_ack !== 1'b0) begin failures++; $display("FAIL bp_a_ack_early: got %b required 0", input_a_ack); end
      @(negedge clk);
      assertions++;
      if (input_a_ack !== 1'b1) begin failures++; $display("FAIL bp_a_ack_rise: got %b required 1", input_a_ack); end
   endtask

   task automatic test_stalls;
      logic [31:0] va, vb, zv, expz;
      logic [7:0]  ea, eb;
      int          bcyc, lat;
      for (int n = 0; n < 300; n++) begin
         ea = 8'($urandom_range(80, 175));
         eb = 8'($urandom_range(80, 175));
         va = {1'($urandom), ea, 23'($urandom)};
         vb = {1'($urandom), eb, 23'($urandom)};
         expz = ref_div(va, vb);
         send_ops(va, vb, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom), bcyc);
         get_z(bcyc, 1'b1, zv, lat);
         assertions++;
         if (zv !== expz) begin
            failures++;
            $display("FAIL stall_value[%0d]: %h / %h got %h required %h", n, va, vb, zv, expz);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] zv;
      int          bcyc, lat;
      logic        stray;
      send_ops(32'h40C0_0000, 32'h4000_0000, 0, 0, 1'b0, bcyc);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      assertions++;
      if (output_z !== 32'd0) begin failures++; $display("FAIL mid_reset_z: got %h required 00000000", output_z); end
      assertions++;
      if (output_z_stb !== 1'b0) begin failures++; $display("FAIL mid_reset_stb: got %b required 0", output_z_stb); end
      assertions++;
      if (input_a_ack !== 1'b0 || input_b_ack !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_acks: got a=%b b=%b required 0 0", input_a_ack, input_b_ack);
      end
      rst = 1'b0;
      @(negedge clk);
      assertions++;
      if (input_a_ack !== 1'b1) begin failures++; $display("FAIL mid_reset_a_ack: got %b required 1", input_a_ack); end
      stray = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         stray |= output_z_stb;
      end
      assertions++;
      if (stray !== 1'b0) begin failures++; $display("FAIL mid_reset_stray_result: stb seen=%b required 0", stray); end
      send_ops(32'h40C0_0000, 32'h4000_0000, 0, 0, 1'b0, bcyc);
      get_z(bcyc, 1'b1, zv, lat);
      assertions++;
      if (zv !== 32'h4040_0000) begin failures++; $display("FAIL mid_reset_next: got %h required 40400000", zv); end
   endtask

   initial begin
      test_reset;
      test_normal;
      test_special;
      test_range;
      test_backpressure;
      test_stalls;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
